// File: rtl/wb_arb_2m_if.sv
// wb_arb_2m_if: bus bundle between the two Wishbone masters, the arbiter and the shared slave port
interface wb_arb_2m_if;
  logic        M0_CYC_IN, M1_CYC_IN, M0_STB_IN, M1_STB_IN, M0_WE_IN, M1_WE_IN;
  logic [3:0]  M0_SEL_IN, M1_SEL_IN;
  logic [31:0] M0_ADR_IN, M1_ADR_IN, M0_DAT_WR_IN, M1_DAT_WR_IN;
  logic        M0_ACK_OUT, M1_ACK_OUT, M0_ERR_OUT, M1_ERR_OUT, M0_GNT_OUT, M1_GNT_OUT;
  logic [31:0] M0_DAT_RD_OUT, M1_DAT_RD_OUT;
  logic        S_CYC_OUT, S_STB_OUT, S_WE_OUT, S_ACK_IN;
  logic [3:0]  S_SEL_OUT;
  logic [31:0] S_ADR_OUT, S_DAT_WR_OUT, S_DAT_RD_IN;
  modport slave (
    input  M0_CYC_IN, M1_CYC_IN, M0_STB_IN, M1_STB_IN, M0_WE_IN, M1_WE_IN, M0_SEL_IN, M1_SEL_IN,
           M0_ADR_IN, M1_ADR_IN, M0_DAT_WR_IN, M1_DAT_WR_IN, S_ACK_IN, S_DAT_RD_IN,
    output M0_ACK_OUT, M1_ACK_OUT, M0_ERR_OUT, M1_ERR_OUT, M0_GNT_OUT, M1_GNT_OUT,
           M0_DAT_RD_OUT, M1_DAT_RD_OUT, S_CYC_OUT, S_STB_OUT, S_WE_OUT, S_SEL_OUT, S_ADR_OUT, S_DAT_WR_OUT
  );
  modport master (
    output M0_CYC_IN, M1_CYC_IN, M0_STB_IN, M1_STB_IN, M0_WE_IN, M1_WE_IN, M0_SEL_IN, M1_SEL_IN,
           M0_ADR_IN, M1_ADR_IN, M0_DAT_WR_IN, M1_DAT_WR_IN, S_ACK_IN, S_DAT_RD_IN,
    input  M0_ACK_OUT, M1_ACK_OUT, M0_ERR_OUT, M1_ERR_OUT, M0_GNT_OUT, M1_GNT_OUT,
           M0_DAT_RD_OUT, M1_DAT_RD_OUT, S_CYC_OUT, S_STB_OUT, S_WE_OUT, S_SEL_OUT, S_ADR_OUT, S_DAT_WR_OUT
  );
endinterface

// File: rtl/wb_arb_2m.sv
// wb_arb_2m: two-master Wishbone classic arbiter with CYC bus lock and round-robin on contention
// Optional STB-without-ACK timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arb_2m #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic         CLK,
  input logic         RST_SYNC,
  wb_arb_2m_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, GNT_M0, GNT_M1} state_t;
  state_t r_state;
  logic   r_last, r_gnt0, r_gnt1;
  logic   w_g0, w_g1, w_req0, w_req1, w_to;
  assign w_g0 = (r_state == GNT_M0) & bus.M0_CYC_IN;
  assign w_g1 = (r_state == GNT_M1) & bus.M1_CYC_IN;
  assign bus.S_CYC_OUT    = w_g0 | w_g1;
  assign bus.S_STB_OUT    = w_g0 ? bus.M0_STB_IN    : w_g1 ? bus.M1_STB_IN    : 1'b0;
  assign bus.S_WE_OUT     = w_g0 ? bus.M0_WE_IN     : w_g1 ? bus.M1_WE_IN     : 1'b0;
  assign bus.S_SEL_OUT    = w_g0 ? bus.M0_SEL_IN    : w_g1 ? bus.M1_SEL_IN    : 4'h0;
  assign bus.S_ADR_OUT    = w_g0 ? bus.M0_ADR_IN    : w_g1 ? bus.M1_ADR_IN    : 32'h0;
  assign bus.S_DAT_WR_OUT = w_g0 ? bus.M0_DAT_WR_IN : w_g1 ? bus.M1_DAT_WR_IN : 32'h0;
  assign bus.M0_ACK_OUT    = w_g0 & bus.S_ACK_IN;
  assign bus.M1_ACK_OUT    = w_g1 & bus.S_ACK_IN;
  assign bus.M0_DAT_RD_OUT = bus.S_DAT_RD_IN;
  assign bus.M1_DAT_RD_OUT = bus.S_DAT_RD_IN;
  assign bus.M0_GNT_OUT    = r_gnt0;
  assign bus.M1_GNT_OUT    = r_gnt1;
`ifdef WB_ARB_TIMEOUT_EN
  logic [31:0] r_cnt;
  logic        r_blk0, r_blk1;
  // An ACK in the expiry cycle suppresses the timeout
  assign w_to = bus.S_STB_OUT & ~bus.S_ACK_IN & (r_cnt == TIMEOUT_CYCLES - 1);
  assign bus.M0_ERR_OUT = w_to & w_g0;
  assign bus.M1_ERR_OUT = w_to & w_g1;
  // A timed-out master stays blocked until it drops CYC and re-requests
  assign w_req0 = bus.M0_CYC_IN & ~r_blk0;
  assign w_req1 = bus.M1_CYC_IN & ~r_blk1;
  always_ff @(posedge CLK) begin
    r_cnt  <= (RST_SYNC | bus.S_ACK_IN | w_to | ~bus.S_CYC_OUT) ? 32'h0 : r_cnt + {31'h0, bus.S_STB_OUT};
    r_blk0 <= ~RST_SYNC & bus.M0_CYC_IN & (r_blk0 | (w_to & w_g0));
    r_blk1 <= ~RST_SYNC & bus.M1_CYC_IN & (r_blk1 | (w_to & w_g1));
  end
`else
  assign w_to = 1'b0;
  assign bus.M0_ERR_OUT = 1'b0;
  assign bus.M1_ERR_OUT = 1'b0;
  assign w_req0 = bus.M0_CYC_IN;
  assign w_req1 = bus.M1_CYC_IN;
`endif
  always_ff @(posedge CLK) begin
    if (RST_SYNC) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_req0 & (~w_req1 | r_last)) begin
            r_state <= GNT_M0;
            r_gnt0  <= 1'b1;
          end else if (w_req1) begin
            r_state <= GNT_M1;
            r_gnt1  <= 1'b1;
          end
        end
        GNT_M0: if (~bus.M0_CYC_IN | w_to) begin
          r_state <= IDLE;
          r_last  <= 1'b0;
          r_gnt0  <= 1'b0;
        end
        GNT_M1: if (~bus.M1_CYC_IN | w_to) begin
          r_state <= IDLE;
          r_last  <= 1'b1;
          r_gnt1  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_arb_2m.sv
// tb_wb_arb_2m: directed checks of grant, lock, round-robin, reset abort and (optionally) timeout
module tb_wb_arb_2m;
  logic CLK = 1'b0;
  logic RST_SYNC;
  int   n_chk = 0;
  int   n_fail = 0;
  wb_arb_2m_if bus ();
  wb_arb_2m #(.TIMEOUT_CYCLES(8)) dut (.CLK(CLK), .RST_SYNC(RST_SYNC), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  task automatic clear_in();
    bus.M0_CYC_IN = 0; bus.M0_STB_IN = 0; bus.M0_WE_IN = 0; bus.M0_SEL_IN = 0;
    bus.M0_ADR_IN = 0; bus.M0_DAT_WR_IN = 0;
    bus.M1_CYC_IN = 0; bus.M1_STB_IN = 0; bus.M1_WE_IN = 0; bus.M1_SEL_IN = 0;
    bus.M1_ADR_IN = 0; bus.M1_DAT_WR_IN = 0;
    bus.S_ACK_IN = 0; bus.S_DAT_RD_IN = 0;
  endtask
  task automatic do_reset();
    clear_in();
    RST_SYNC = 1;
    tick();
    tick();
    RST_SYNC = 0;
  endtask
  initial begin
    do_reset();
    settle();
    chk("rst_gnt0", bus.M0_GNT_OUT, 0);
    chk("rst_gnt1", bus.M1_GNT_OUT, 0);
    chk("rst_scyc", bus.S_CYC_OUT, 0);
    chk("rst_sadr", bus.S_ADR_OUT, 0);
    chk("rst_ack", {bus.M0_ACK_OUT, bus.M1_ACK_OUT, bus.M0_ERR_OUT, bus.M1_ERR_OUT}, 0);
    // single M0 read
    tick();
    bus.M0_CYC_IN = 1; bus.M0_STB_IN = 1; bus.M0_SEL_IN = 4'hF; bus.M0_ADR_IN = 32'h1FC0_0000;
    settle();
    chk("rd_scyc_req", bus.S_CYC_OUT, 0);
    tick();
    settle();
    chk("rd_gnt0", bus.M0_GNT_OUT, 1);
    chk("rd_scyc", bus.S_CYC_OUT, 1);
    chk("rd_sstb", bus.S_STB_OUT, 1);
    chk("rd_sadr", bus.S_ADR_OUT, 32'h1FC0_0000);
    chk("rd_ack_early", bus.M0_ACK_OUT, 0);
    tick();
    bus.S_ACK_IN = 1; bus.S_DAT_RD_IN = 32'hDEAD_BEEF;
    settle();
    chk("rd_ack0", bus.M0_ACK_OUT, 1);
    chk("rd_dat0", bus.M0_DAT_RD_OUT, 32'hDEAD_BEEF);
    chk("rd_ack1", bus.M1_ACK_OUT, 0);
    tick();
    bus.S_ACK_IN = 0; bus.M0_CYC_IN = 0; bus.M0_STB_IN = 0;
    settle();
    chk("rd_drop_scyc", bus.S_CYC_OUT, 0);
    chk("rd_drop_ack", bus.M0_ACK_OUT, 0);
    tick();
    settle();
    chk("rd_idle_gnt0", bus.M0_GNT_OUT, 0);
    // contention from reset: strict alternation M0,M1,M0,M1
    do_reset();
    bus.M0_ADR_IN = 32'hA0; bus.M1_ADR_IN = 32'hB1;
    bus.M0_CYC_IN = 1; bus.M0_STB_IN = 1; bus.M1_CYC_IN = 1; bus.M1_STB_IN = 1;
    for (int r = 0; r < 4; r++) begin
      tick();
      settle();
      chk($sformatf("rr%0d_gnt0", r), bus.M0_GNT_OUT, (r % 2 == 0) ? 1 : 0);
      chk($sformatf("rr%0d_gnt1", r), bus.M1_GNT_OUT, (r % 2 == 1) ? 1 : 0);
      chk($sformatf("rr%0d_sadr", r), bus.S_ADR_OUT, (r % 2 == 0) ? 32'hA0 : 32'hB1);
      if (r % 2 == 0) bus.M0_CYC_IN = 0; else bus.M1_CYC_IN = 0;
      settle();
      chk($sformatf("rr%0d_drop", r), bus.S_CYC_OUT, 0);
      tick();
      settle();
      chk($sformatf("rr%0d_idle", r), {bus.M0_GNT_OUT, bus.M1_GNT_OUT}, 0);
      if (r % 2 == 0) bus.M0_CYC_IN = 1; else bus.M1_CYC_IN = 1;
    end
    clear_in();
    tick();
    // locked M1 write burst while M0 waits
    bus.M1_CYC_IN = 1;
    tick();
    settle();
    chk("lk_gnt1", bus.M1_GNT_OUT, 1);
    bus.M0_CYC_IN = 1; bus.M0_STB_IN = 1; bus.M0_ADR_IN = 32'hA0;
    for (int i = 1; i <= 4; i++) begin
      bus.M1_STB_IN = 1; bus.M1_WE_IN = 1; bus.M1_SEL_IN = 4'hF;
      bus.M1_DAT_WR_IN = i; bus.M1_ADR_IN = 32'h100 + 4 * i; bus.S_ACK_IN = 1;
      settle();
      chk($sformatf("lk%0d_wdat", i), bus.S_DAT_WR_OUT, i);
      chk($sformatf("lk%0d_sadr", i), bus.S_ADR_OUT, 32'h100 + 4 * i);
      chk($sformatf("lk%0d_we_sel", i), {bus.S_WE_OUT, bus.S_SEL_OUT}, 5'h1F);
      chk($sformatf("lk%0d_acks", i), {bus.M1_ACK_OUT, bus.M0_ACK_OUT, bus.M0_GNT_OUT}, 3'b100);
      tick();
    end
    bus.M1_CYC_IN = 0; bus.M1_STB_IN = 0; bus.S_ACK_IN = 0;
    settle();
    chk("lk_drop_scyc", bus.S_CYC_OUT, 0);
    tick();
    settle();
    chk("lk_idle", {bus.M0_GNT_OUT, bus.M1_GNT_OUT}, 0);
    tick();
    settle();
    chk("lk_m0_gnt", bus.M0_GNT_OUT, 1);
    chk("lk_m0_adr", bus.S_ADR_OUT, 32'hA0);
    // reset while M0 granted with STB pending
    RST_SYNC = 1;
    tick();
    RST_SYNC = 0; bus.S_ACK_IN = 1;
    settle();
    chk("mr_scyc", bus.S_CYC_OUT, 0);
    chk("mr_sstb", bus.S_STB_OUT, 0);
    chk("mr_gnt", {bus.M0_GNT_OUT, bus.M1_GNT_OUT}, 0);
    chk("mr_ack", bus.M0_ACK_OUT, 0);
    chk("mr_err", {bus.M0_ERR_OUT, bus.M1_ERR_OUT}, 0);
`ifdef WB_ARB_TIMEOUT_EN
    // slave never ACKs: ERR in the 8th cycle, then pending M1 wins
    do_reset();
    bus.M0_CYC_IN = 1; bus.M0_STB_IN = 1;
    tick();
    bus.M1_CYC_IN = 1; bus.M1_STB_IN = 1;
    for (int k = 1; k <= 8; k++) begin
      settle();
      chk($sformatf("to%0d_err0", k), bus.M0_ERR_OUT, (k == 8) ? 1 : 0);
      if (k < 8) tick();
    end
    tick();
    settle();
    chk("to_idle", {bus.M0_GNT_OUT, bus.M1_GNT_OUT}, 0);
    chk("to_scyc", bus.S_CYC_OUT, 0);
    chk("to_err_once", bus.M0_ERR_OUT, 0);
    tick();
    settle();
    chk("to_m1_gnt", {bus.M0_GNT_OUT, bus.M1_GNT_OUT}, 2'b01);
    // ACK coincides with expiry: ACK wins
    clear_in();
    tick();
    tick();
    bus.M0_CYC_IN = 1; bus.M0_STB_IN = 1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      bus.S_ACK_IN = (k == 8);
      settle();
      if (k == 8) begin
        chk("col_ack0", bus.M0_ACK_OUT, 1);
        chk("col_err0", bus.M0_ERR_OUT, 0);
      end else begin
        chk($sformatf("col%0d_err0", k), bus.M0_ERR_OUT, 0);
        tick();
      end
    end
    tick();
    settle();
    chk("col_gnt0", bus.M0_GNT_OUT, 1);
`endif
    clear_in();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_arb_2m.md
# wb_arb_2m

Two-master, one-slave Wishbone (classic, non-pipelined) arbiter. Shares the system bus between the MIPS1 core data/instruction master (M0) and the DMA master (M1), presenting a single master port to the memory/peripheral interconnect. Grants are held for a master's whole CYC assertion (bus lock), with round-robin selection when both request. Bus events at its slave-side port must match what the core monitor records as M2S/S2M events.

## Interface
- TIMEOUT_CYCLES, 255: cycles of STB-without-ACK before a forced error; only used with the timeout feature.
- CLK  in  1  system clock; all logic on rising edge
- RST_SYNC  in  1  synchronous reset, active-high
- M0_CYC_IN, M1_CYC_IN  in  1  master cycle request
- M0_STB_IN, M1_STB_IN  in  1  master strobe
- M0_WE_IN, M1_WE_IN  in  1  1 = write
- M0_SEL_IN, M1_SEL_IN  in  4  byte selects
- M0_ADR_IN, M1_ADR_IN  in  32  byte address
- M0_DAT_WR_IN, M1_DAT_WR_IN  in  32  write data
- M0_ACK_OUT, M1_ACK_OUT  out  1  ACK routed to granted master only
- M0_ERR_OUT, M1_ERR_OUT  out  1  timeout error (0 when timeout compiled out)
- M0_DAT_RD_OUT, M1_DAT_RD_OUT  out  32  read data (broadcast from slave)
- M0_GNT_OUT, M1_GNT_OUT  out  1  registered grant status
- S_CYC_OUT, S_STB_OUT, S_WE_OUT  out  1  muxed from granted master; forced 0 when no grant
- S_SEL_OUT  out  4, S_ADR_OUT  out  32, S_DAT_WR_OUT  out  32: muxed; 0 when no grant
- S_ACK_IN  in  1, S_DAT_RD_IN  in  32: slave response

## Operation
- States: IDLE, GNT_M0, GNT_M1 (registered). LAST_GNT register records most recent winner.
- IDLE: if exactly one Mx_CYC_IN high -> GNT_Mx. If both high -> grant the master that is NOT LAST_GNT. Neither -> stay.
- GNT_Mx: slave outputs follow Mx combinationally; S_ACK_IN routed to Mx_ACK_OUT; other master's ACK/ERR held 0. Stay while Mx_CYC_IN high (multiple STB/ACK beats, RMW locked). Mx_CYC_IN low -> IDLE, LAST_GNT <= x.
- A master whose CYC drops in IDLE before being granted is simply not granted; no state kept.
- Mx_DAT_RD_OUT = S_DAT_RD_IN for both masters; only ACK qualifies it.
- S_ACK_IN while in IDLE is ignored (not forwarded).
- Reset values: state IDLE, LAST_GNT = M1 (so M0 wins first contention), all outputs 0, timeout counter 0.
- Reset asserted mid-cycle: next edge forces IDLE; S_CYC_OUT/S_STB_OUT low that cycle; the in-flight transfer is abandoned, no ACK forwarded.

## Timing
- Arbitration latency: CYC rise at edge N -> state GNT at edge N+1 -> S_CYC_OUT high during cycle N+1.
- Release: CYC low sampled at edge K -> IDLE after K; S_CYC_OUT low in same cycle CYC drops (combinational mux gated by Mx_CYC_IN).
- Mandatory one IDLE cycle between back-to-back grants (handover latency 2 cycles from CYC drop to other master's S_CYC_OUT).
- ACK/DAT_RD path is purely combinational slave->master (zero added latency).
- Mx_GNT_OUT = registered state decode.

## Configuration
- WB_ARB_TIMEOUT_EN defined: counter increments each cycle with S_STB_OUT high and S_ACK_IN low, clears on ACK or state change. On reaching TIMEOUT_CYCLES: assert Mx_ERR_OUT for exactly one cycle to granted master, state -> IDLE, LAST_GNT <= x, counter clears; S_CYC_OUT low from next cycle even if Mx_CYC_IN still high (master must drop CYC and re-request). ACK arriving in same cycle as timeout wins: ACK forwarded, no ERR.
- Not defined: no counter logic, ERR outputs tied 0, a hung slave locks the bus indefinitely.

## Test plan
- Single M0 read: M0 CYC/STB, ADR=0x1FC0_0000, slave ACKs 2 cycles later with 0xDEAD_BEEF -> S_ADR_OUT matches from cycle after request, M0_ACK_OUT one cycle, M0 gets 0xDEAD_BEEF, M1_ACK_OUT stays 0.
- Simultaneous request from reset: both CYC high same cycle -> M0 granted first; after M0 drops CYC, one IDLE cycle, M1 granted; repeat contention -> M0 again (strict alternation over 4 rounds).
- Locked burst: M1 holds CYC for 4 write beats (SEL=0xF, data 0x1..0x4) while M0 requests -> M0 not granted until M1 drops CYC; all 4 writes seen at slave in order.
- Reset mid-cycle: RST_SYNC pulsed while GNT_M0 with STB pending -> S_CYC_OUT low next cycle, all GNT 0, late S_ACK_IN not forwarded.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): slave never ACKs -> M0_ERR_OUT high exactly once, 8 cycles after STB asserted; state IDLE; pending M1 granted next.
- Timeout/ACK collision: ACK on the 8th cycle -> M0_ACK_OUT high, M0_ERR_OUT stays 0.
